// File: rtl/apb_mem_completer_if.sv
// rtl/apb_mem_completer_if.sv - APB4 bus bundle between a requester and apb_mem_completer
interface apb_mem_completer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_mem_completer.sv
// rtl/apb_mem_completer.sv - APB4 completer with word memory, wait states and range errors
// Optional byte-lane write strobes: APB_COMPLETER_PSTRB_EN
module apb_mem_completer #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_WORDS   = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic                clk,
    input  logic                rst,
    apb_mem_completer_if.slave  bus
);
    localparam int                    IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int                    NBYTES  = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LIMIT   = ADDR_WIDTH'(MEM_WORDS * 4);
    localparam logic [3:0]            WS_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    state_t                r_state, w_state_nx;
    logic [3:0]            r_cnt, w_cnt_nx;
    logic                  r_pready, w_pready_nx;
    logic                  r_pslverr, w_pslverr_nx;
    logic [DATA_WIDTH-1:0] r_prdata, w_prdata_nx;

    logic [IDX_W-1:0]      r_word;
    logic                  r_write;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NBYTES-1:0]     r_strb;

    logic                  w_latch;
    logic                  w_mem_we;
    logic                  w_err_in;
    logic [IDX_W-1:0]      w_word_in;
    logic [DATA_WIDTH-1:0] w_wr_word;
    logic                  w_unused;

    assign w_word_in = bus.paddr[IDX_W+1:2];
    // No address wrap: any set upper bit lands beyond LIMIT and is an error
    assign w_err_in  = (bus.paddr >= LIMIT);
    assign w_unused  = ^{bus.paddr[1:0], r_strb};

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_pready_nx  = 1'b0;
        w_pslverr_nx = 1'b0;
        w_prdata_nx  = r_prdata;
        w_latch      = 1'b0;
        w_mem_we     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.psel && !bus.penable) begin
                    w_latch = 1'b1;
                    if (WAIT_STATES == 0) begin
                        w_state_nx   = DONE;
                        w_pready_nx  = 1'b1;
                        w_pslverr_nx = w_err_in;
                        if (!bus.pwrite)
                            w_prdata_nx = w_err_in ? '0 : r_mem[w_word_in];
                    end else begin
                        w_state_nx = WAIT;
                        w_cnt_nx   = WS_INIT;
                    end
                end
            end
            WAIT: begin
                if (!bus.psel) begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt == 4'd1) begin
                    w_state_nx   = DONE;
                    w_cnt_nx     = '0;
                    w_pready_nx  = 1'b1;
                    w_pslverr_nx = r_err;
                    if (!r_write)
                        w_prdata_nx = r_err ? '0 : r_mem[r_word];
                end else begin
                    w_cnt_nx = r_cnt - 4'd1;
                end
            end
            DONE: begin
                w_state_nx = IDLE;
                w_mem_we   = bus.psel && bus.penable && bus.pwrite && !r_err;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_wr_word = r_wdata;
`ifdef APB_COMPLETER_PSTRB_EN
        for (int i = 0; i < NBYTES; i++)
            w_wr_word[i*8 +: 8] = r_strb[i] ? r_wdata[i*8 +: 8] : r_mem[r_word][i*8 +: 8];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_pready  <= w_pready_nx;
            r_pslverr <= w_pslverr_nx;
            r_prdata  <= w_prdata_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_latch) begin
            r_word  <= w_word_in;
            r_write <= bus.pwrite;
            r_err   <= w_err_in;
            r_wdata <= bus.pwdata;
            r_strb  <= bus.pstrb;
        end
    end

    // Memory is deliberately left out of reset so contents survive it
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we)
            r_mem[r_word] <= w_wr_word;
    end

    assign bus.prdata  = r_prdata;
    assign bus.pready  = r_pready;
    assign bus.pslverr = r_pslverr;
endmodule

// File: tb/tb_apb_mem_completer.sv
// tb/tb_apb_mem_completer.sv - randomized self-checking bench for apb_mem_completer
module tb_apb_mem_completer;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 64;
    localparam int WS = 1;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [31:0] ref_mem [MW];
    logic [31:0] exp_prdata;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_mem_completer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_mem_completer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW), .WAIT_STATES(WS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic ref_err(input logic [31:0] a);
        return a >= 32'(MW * 4);
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
`ifdef APB_COMPLETER_PSTRB_EN
            if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
`else
            r[i*8 +: 8] = d[i*8 +: 8];
            if (s[i] === 1'bx) r = 'x;
`endif
        end
        return r;
    endfunction

    function automatic void ref_access(input logic wr, input logic [31:0] a,
                                       input logic [31:0] d, input logic [3:0] s);
        if (wr) begin
            if (!ref_err(a)) ref_mem[a >> 2] = ref_merge(ref_mem[a >> 2], d, s);
        end else begin
            exp_prdata = ref_err(a) ? 32'h0 : ref_mem[a >> 2];
        end
    endfunction

    // Pure driver: setup cycle, then access cycles until pready (bounded)
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic se,
                        output int low, output logic early_err, output logic tmo);
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
        bus.paddr = a; bus.pwdata = d; bus.pstrb = s;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        low = 0;
        early_err = 1'b0;
        while (bus.pready !== 1'b1 && low < 40) begin
            if (bus.pslverr !== 1'b0) early_err = 1'b1;
            low++;
            @(posedge clk); #1;
        end
        tmo = (bus.pready !== 1'b1);
        rd  = bus.prdata;
        se  = bus.pslverr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.psel = 1'b0; bus.penable = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({bus.pready, bus.pslverr, bus.prdata} !== 34'h0) begin
            n_err++;
            $display("FAIL reset: pready=%b pslverr=%b prdata=%h, want 0/0/0",
                     bus.pready, bus.pslverr, bus.prdata);
        end
        rst = 1'b0;
        exp_prdata = 32'h0;
    endtask

    task automatic test_fill;
        logic [31:0] rd, d;
        logic se, ee, to;
        int low;
        for (int w = 0; w < MW; w++) begin
            d = $urandom;
            xfer(1'b1, 32'(w * 4), d, 4'hF, rd, se, low, ee, to);
            ref_access(1'b1, 32'(w * 4), d, 4'hF);
            n_vec++;
            if (to || se !== 1'b0 || low != WS || ee) begin
                n_err++;
                $display("FAIL fill[%0d]: to=%b pslverr=%b low=%0d, want 0/0/%0d", w, to, se, low, WS);
            end
        end
        idle(1);
    endtask

    task automatic test_basic;
        logic [31:0] rd;
        logic se, ee, to;
        int low;
        xfer(1'b1, 32'h0F0, 32'h000A3210, 4'hF, rd, se, low, ee, to);
        ref_access(1'b1, 32'h0F0, 32'h000A3210, 4'hF);
        n_vec++;
        if (to || se !== 1'b0 || low != WS || ee || rd !== exp_prdata) begin
            n_err++;
            $display("FAIL basic_wr: to=%b pslverr=%b low=%0d prdata=%h, want 0/0/%0d/%h",
                     to, se, low, rd, WS, exp_prdata);
        end
        idle(2);
        xfer(1'b0, 32'h0F0, 32'h0, 4'h0, rd, se, low, ee, to);
        ref_access(1'b0, 32'h0F0, 32'h0, 4'h0);
        n_vec++;
        if (to || se !== 1'b0 || low != WS || ee || rd !== 32'h000A3210) begin
            n_err++;
            $display("FAIL basic_rd: to=%b pslverr=%b low=%0d prdata=%h, want 0/0/%0d/000a3210",
                     to, se, low, rd, WS);
        end
        idle(3);
        n_vec++;
        if (bus.prdata !== 32'h000A3210 || bus.pready !== 1'b0 || bus.pslverr !== 1'b0) begin
            n_err++;
            $display("FAIL hold_idle: prdata=%h pready=%b pslverr=%b, want 000a3210/0/0",
                     bus.prdata, bus.pready, bus.pslverr);
        end
    endtask

    task automatic test_error;
        logic [31:0] rd;
        logic se, ee, to;
        int low;
        logic [31:0] addrs [4] = '{32'h100, 32'hFFFF_0000, 32'h0FC, 32'h0000_0103};
        xfer(1'b1, 32'h100, 32'h01021034, 4'hF, rd, se, low, ee, to);
        ref_access(1'b1, 32'h100, 32'h01021034, 4'hF);
        n_vec++;
        if (to || se !== 1'b1 || low != WS || ee) begin
            n_err++;
            $display("FAIL err_wr: to=%b pslverr=%b low=%0d, want 0/1/%0d", to, se, low, WS);
        end
        for (int k = 0; k < 4; k++) begin
            xfer(1'b0, addrs[k], 32'h0, 4'h0, rd, se, low, ee, to);
            ref_access(1'b0, addrs[k], 32'h0, 4'h0);
            n_vec++;
            if (to || se !== ref_err(addrs[k]) || rd !== exp_prdata || ee) begin
                n_err++;
                $display("FAIL err_rd[%h]: to=%b pslverr=%b prdata=%h, want 0/%b/%h",
                         addrs[k], to, se, rd, ref_err(addrs[k]), exp_prdata);
            end
        end
        xfer(1'b0, 32'h000, 32'h0, 4'h0, rd, se, low, ee, to);
        ref_access(1'b0, 32'h000, 32'h0, 4'h0);
        n_vec++;
        if (to || se !== 1'b0 || rd !== exp_prdata) begin
            n_err++;
            $display("FAIL err_nowrap: to=%b pslverr=%b prdata=%h, want 0/0/%h", to, se, rd, exp_prdata);
        end
        idle(1);
    endtask

    task automatic test_strobe;
        logic [31:0] rd;
        logic se, ee, to;
        int low;
        logic [31:0] wd [3] = '{32'hFFFFFFFF, 32'h3187EFC6, 32'h12345678};
        logic [3:0]  ws [3] = '{4'hF, 4'h3, 4'h0};
        for (int k = 0; k < 3; k++) begin
            xfer(1'b1, 32'h050, wd[k], ws[k], rd, se, low, ee, to);
            ref_access(1'b1, 32'h050, wd[k], ws[k]);
            n_vec++;
            if (to || se !== 1'b0 || rd !== exp_prdata) begin
                n_err++;
                $display("FAIL strb_wr[%0d]: to=%b pslverr=%b prdata=%h, want 0/0/%h",
                         k, to, se, rd, exp_prdata);
            end
            xfer(1'b0, 32'h050, 32'h0, 4'h0, rd, se, low, ee, to);
            ref_access(1'b0, 32'h050, 32'h0, 4'h0);
            n_vec++;
            if (to || se !== 1'b0 || rd !== exp_prdata) begin
                n_err++;
                $display("FAIL strb_rd[%0d]: to=%b pslverr=%b prdata=%h, want 0/0/%h",
                         k, to, se, rd, exp_prdata);
            end
        end
        idle(1);
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        logic se, ee, to;
        int low, t0;
        t0 = cyc;
        for (int k = 0; k < 16; k++) begin
            logic        wr;
            logic [31:0] a, d;
            wr = (k < 8);
            a  = 32'h0B0 + 32'((k % 8) * 4);
            d  = 32'hC0D942F0 + 32'(k % 8);
            xfer(wr, a, d, 4'hF, rd, se, low, ee, to);
            ref_access(wr, a, d, 4'hF);
            n_vec++;
            if (to || se !== 1'b0 || low != WS || ee || rd !== exp_prdata
                || (!wr && rd !== d)) begin
                n_err++;
                $display("FAIL b2b[%0d]: to=%b pslverr=%b low=%0d prdata=%h, want 0/0/%0d/%h",
                         k, to, se, low, rd, WS, wr ? exp_prdata : d);
            end
        end
        n_vec++;
        if (cyc - t0 != 16 * (2 + WS)) begin
            n_err++;
            $display("FAIL b2b_cycles: took %0d cycles, want %0d", cyc - t0, 16 * (2 + WS));
        end
        idle(1);
    endtask

    task automatic test_random;
        logic [31:0] rd, a, d;
        logic [3:0]  s;
        logic        se, ee, to, wr;
        int          low;
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 9))
                0:       a = $urandom | 32'h0000_1000;
                1:       a = 32'h100 + 32'($urandom_range(0, 63));
                default: a = 32'($urandom_range(0, MW * 4 - 1));
            endcase
            wr = $urandom_range(0, 1) == 1;
            d  = $urandom;
            s  = 4'($urandom_range(0, 15));
            xfer(wr, a, d, s, rd, se, low, ee, to);
            ref_access(wr, a, d, s);
            n_vec++;
            if (to || se !== ref_err(a) || low != WS || ee || rd !== exp_prdata) begin
                n_err++;
                $display("FAIL rand[%0d] %s a=%h: to=%b pslverr=%b low=%0d prdata=%h, want 0/%b/%0d/%h",
                         k, wr ? "wr" : "rd", a, to, se, low, rd, ref_err(a), WS, exp_prdata);
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        logic se, ee, to;
        int low;
        @(posedge clk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 32'h0F4; bus.pwdata = 32'hDEADBEEF; bus.pstrb = 4'hF;
        @(posedge clk); #1;
        bus.penable = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if ({bus.pready, bus.pslverr, bus.prdata} !== 34'h0) begin
            n_err++;
            $display("FAIL rst_mid: pready=%b pslverr=%b prdata=%h, want 0/0/0",
                     bus.pready, bus.pslverr, bus.prdata);
        end
        rst = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0;
        exp_prdata = 32'h0;
        idle(1);
        xfer(1'b0, 32'h0F4, 32'h0, 4'h0, rd, se, low, ee, to);
        ref_access(1'b0, 32'h0F4, 32'h0, 4'h0);
        n_vec++;
        if (to || se !== 1'b0 || rd !== exp_prdata) begin
            n_err++;
            $display("FAIL rst_mid_rd: to=%b pslverr=%b prdata=%h, want 0/0/%h", to, se, rd, exp_prdata);
        end
        idle(1);
    endtask

    initial begin
        test_reset;
        test_fill;
        test_basic;
        test_error;
        test_strobe;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
